// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU-side and memory-side bus bundle for data_cache
//
// Signals:
//   read, write        CPU load/store request (held stable while busywait=1)
//   address, writedata CPU byte address and store word
//   readdata, busywait load word and pipeline stall
//   mem_read/mem_write main-memory block read/write strobes
//   mem_address        block address (byte address [31:4])
//   mem_writedata      victim block, word 0 in [31:0]
//   mem_readdata       fetched block, word 0 in [31:0]
//   mem_busywait       memory busy; transfer done on first low cycle under a strobe
// Modports: slave = cache side, master = CPU/memory side.
interface data_cache_if;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache, 8 sets x 4 words
//
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  synchronous active-high reset; clears valid/dirty and returns FSM to IDLE
//   bus    data_cache_if.slave, CPU request/response and main-memory block bus
module data_cache (
  input  logic         clk_i,
  input  logic         rst_i,
  data_cache_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_FETCH  = 2'd2,
    UPDATE     = 2'd3
  } state_e;

  state_e        state_q, state_d;

  logic [127:0]  data_q  [8];
  logic [24:0]   tag_q   [8];
  logic [7:0]    valid_q;
  logic [7:0]    dirty_q;
  logic [127:0]  buf_q;

  logic [24:0]   addr_tag;
  logic [2:0]    addr_idx;
  logic [1:0]    addr_off;
  logic [6:0]    word_lsb;
  logic [31:0]   sel_word;
  logic          hit;
  logic          req;
  logic          write_hit;

  logic          busywait_w;
  logic          mem_read_w;
  logic          mem_write_w;
  logic [27:0]   mem_address_w;
  logic [127:0]  mem_writedata_w;
  logic [31:0]   readdata_w;

  // Byte-select bits carry no information for a word-granular cache.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^bus.address[1:0];

  assign addr_tag = bus.address[31:7];
  assign addr_idx = bus.address[6:4];
  assign addr_off = bus.address[3:2];
  assign word_lsb = {addr_off, 5'b00000};
  assign sel_word = data_q[addr_idx][word_lsb +: 32];
  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

  // Requests are ignored while reset is held so every output sits at zero.
  assign req      = (bus.read || bus.write) && !rst_i;

  always_comb begin
    state_d         = state_q;
    busywait_w      = 1'b0;
    mem_read_w      = 1'b0;
    mem_write_w     = 1'b0;
    mem_address_w   = 28'd0;
    mem_writedata_w = 128'd0;
    readdata_w      = 32'd0;
    write_hit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // WRITE wins when both strobes are present.
            if (bus.write) begin
              write_hit = 1'b1;
            end else begin
              readdata_w = sel_word;
            end
          end else begin
            busywait_w = 1'b1;
            state_d    = dirty_q[addr_idx] ? WRITE_BACK : MEM_FETCH;
          end
        end
      end
      WRITE_BACK: begin
        busywait_w      = 1'b1;
        mem_write_w     = 1'b1;
        mem_address_w   = {tag_q[addr_idx], addr_idx};
        mem_writedata_w = data_q[addr_idx];
        if (!bus.mem_busywait) begin
          state_d = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        busywait_w    = 1'b1;
        mem_read_w    = 1'b1;
        mem_address_w = bus.address[31:4];
        if (!bus.mem_busywait) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busywait_w = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busywait      = busywait_w;
  assign bus.mem_read      = mem_read_w;
  assign bus.mem_write     = mem_write_w;
  assign bus.mem_address   = mem_address_w;
  assign bus.mem_writedata = mem_writedata_w;
  assign bus.readdata      = readdata_w;

  // Control state: FSM plus valid/dirty, the only state that reset clears.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 8'd0;
      dirty_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (write_hit) begin
        dirty_q[addr_idx] <= 1'b1;
      end
      if (state_q == UPDATE) begin
        valid_q[addr_idx] <= 1'b1;
        dirty_q[addr_idx] <= 1'b0;
      end
    end
  end

  // Data/tag arrays and fetch buffer. A reset mid-fetch leaves the FSM in
  // IDLE before UPDATE, so a partially fetched buffer is never installed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == MEM_FETCH && !bus.mem_busywait) begin
      buf_q <= bus.mem_readdata;
    end
    if (write_hit) begin
      data_q[addr_idx][word_lsb +: 32] <= bus.writedata;
    end
    if (!rst_i && state_q == UPDATE) begin
      data_q[addr_idx] <= buf_q;
      tag_q[addr_idx]  <= addr_tag;
    end
  end

endmodule
